// File: rtl/shifter_arbiter_if.sv
// Request/result bus for shifter_arbiter: two packed requesters in, one registered result out.
// slave = arbiter side, master = requesters plus result consumer.
interface shifter_arbiter_if;
  logic [1:0]  Req;
  logic [63:0] Req_Data;
  logic [3:0]  Req_Type;
  logic [15:0] Req_Amt;
  logic [1:0]  Req_RegShift;
  logic [1:0]  Req_Cin;
  logic [1:0]  Gnt;
  logic        Res_Valid;
  logic        Res_Ready;
  logic [31:0] Res_Data;
  logic        Res_Cout;
  logic        Res_Id;

  modport slave (
    input  Req, Req_Data, Req_Type, Req_Amt, Req_RegShift, Req_Cin, Res_Ready,
    output Gnt, Res_Valid, Res_Data, Res_Cout, Res_Id
  );

  modport master (
    output Req, Req_Data, Req_Type, Req_Amt, Req_RegShift, Req_Cin, Res_Ready,
    input  Gnt, Res_Valid, Res_Data, Res_Cout, Res_Id
  );
endinterface

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one external combinational barrel shifter between two requesters.
// Define SHIFTER_ARB_REGSHIFT_EN to enable fix-up of register-specified 8-bit shift amounts.
module shifter_arbiter (
  input  logic              CLK,
  input  logic              nRESET,
  shifter_arbiter_if.slave  bus,
  output logic              BS_Enable,
  output logic [31:0]       BS_Input_Bus,
  output logic [1:0]        BS_Shift_Type,
  output logic [4:0]        BS_Shift_Amt,
  output logic              BS_Cin,
  input  logic [31:0]       BS_Shift_Output,
  input  logic              BS_Cout
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_ptr;
  logic [31:0] r_data;
  logic [1:0]  r_type;
  logic [7:0]  r_amt;
  logic        r_cin;
  logic        r_id;
`ifdef SHIFTER_ARB_REGSHIFT_EN
  logic        r_regshift;
`endif

  logic        r_res_valid;
  logic [31:0] r_res_data;
  logic        r_res_cout;
  logic        r_res_id;

  logic        w_any;
  logic        w_sel;
  logic [31:0] w_sel_data;
  logic [1:0]  w_sel_type;
  logic [7:0]  w_sel_amt;
  logic        w_sel_cin;
  logic        w_sel_rs;
  logic [1:0]  w_gnt;
  logic        w_capture;
  logic        w_load;
  logic        w_hs;
  logic        w_bs_en;
  logic        w_fix_zero;
  logic [31:0] w_res_data;
  logic        w_res_cout;

  // Pointer only matters when both request; a lone requester always wins
  always_comb begin
    w_any = |bus.Req;
    if (&bus.Req) begin
      w_sel = r_ptr;
    end else begin
      w_sel = bus.Req[1];
    end
  end

  always_comb begin
    w_sel_data = w_sel ? bus.Req_Data[63:32] : bus.Req_Data[31:0];
    w_sel_type = w_sel ? bus.Req_Type[3:2]   : bus.Req_Type[1:0];
    w_sel_amt  = w_sel ? bus.Req_Amt[15:8]   : bus.Req_Amt[7:0];
    w_sel_cin  = w_sel ? bus.Req_Cin[1]      : bus.Req_Cin[0];
    w_sel_rs   = w_sel ? bus.Req_RegShift[1] : bus.Req_RegShift[0];
  end

`ifdef SHIFTER_ARB_REGSHIFT_EN
  assign w_fix_zero = r_regshift && (r_amt == 8'd0);
`else
  logic w_unused;
  assign w_fix_zero = 1'b0;
  assign w_unused   = ^{w_sel_rs, r_amt[7:5]};
`endif

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Grant is also gated by nRESET so nothing is offered before the first edge after reset
  always_comb begin
    w_next    = r_state;
    w_gnt     = '0;
    w_capture = 1'b0;
    w_load    = 1'b0;
    w_hs      = 1'b0;
    w_bs_en   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any && nRESET) begin
          w_gnt     = w_sel ? 2'b10 : 2'b01;
          w_capture = 1'b1;
          w_next    = SHIFT;
        end
      end
      SHIFT: begin
        w_bs_en = ~w_fix_zero;
        w_load  = 1'b1;
        w_next  = DONE;
      end
      DONE: begin
        if (bus.Res_Ready) begin
          w_hs   = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_res_data = BS_Shift_Output;
    w_res_cout = BS_Cout;
`ifdef SHIFTER_ARB_REGSHIFT_EN
    // Amounts of 32 and above exceed the shifter's 5-bit field and are resolved here
    if (r_regshift && (r_amt >= 8'd32)) begin
      case (r_type)
        2'b00: begin
          w_res_data = '0;
          w_res_cout = (r_amt == 8'd32) ? r_data[0] : 1'b0;
        end
        2'b01: begin
          w_res_data = '0;
          w_res_cout = (r_amt == 8'd32) ? r_data[31] : 1'b0;
        end
        2'b10: begin
          w_res_data = {32{r_data[31]}};
          w_res_cout = r_data[31];
        end
        default: begin
          if (r_amt[4:0] == 5'd0) begin
            w_res_data = r_data;
            w_res_cout = r_data[31];
          end
        end
      endcase
    end
`endif
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_data     <= '0;
      r_type     <= '0;
      r_amt      <= '0;
      r_cin      <= 1'b0;
      r_id       <= 1'b0;
`ifdef SHIFTER_ARB_REGSHIFT_EN
      r_regshift <= 1'b0;
`endif
    end else if (w_capture) begin
      r_data     <= w_sel_data;
      r_type     <= w_sel_type;
      r_amt      <= w_sel_amt;
      r_cin      <= w_sel_cin;
      r_id       <= w_sel;
`ifdef SHIFTER_ARB_REGSHIFT_EN
      r_regshift <= w_sel_rs;
`endif
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_cout  <= 1'b0;
      r_res_id    <= 1'b0;
      r_ptr       <= 1'b0;
    end else if (w_load) begin
      r_res_valid <= 1'b1;
      r_res_data  <= w_res_data;
      r_res_cout  <= w_res_cout;
      r_res_id    <= r_id;
    end else if (w_hs) begin
      r_res_valid <= 1'b0;
      r_ptr       <= ~r_res_id;
    end
  end

  assign bus.Gnt       = w_gnt;
  assign bus.Res_Valid = r_res_valid;
  assign bus.Res_Data  = r_res_data;
  assign bus.Res_Cout  = r_res_cout;
  assign bus.Res_Id    = r_res_id;

  assign BS_Enable     = w_bs_en;
  assign BS_Input_Bus  = r_data;
  assign BS_Shift_Type = r_type;
  assign BS_Shift_Amt  = r_amt[4:0];
  assign BS_Cin        = r_cin;

endmodule

// File: doc/shifter_arbiter.md
SHIFTER_ARBITER -- requirements
Module: shifter_arbiter

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port nRESET, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port Req, input, 2; bit k set = requester k (0 = ALU operand, 1 = address path) requests a shift.
REQ-004 SHALL have port Req_Data, input, 64; operand for requester k on bits [32k+31:32k].
REQ-005 SHALL have port Req_Type, input, 4; shift type for requester k on [2k+1:2k]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-006 SHALL have port Req_Amt, input, 16; shift amount for requester k on [8k+7:8k].
REQ-007 SHALL have port Req_RegShift, input, 2; bit k set = requester k's amount comes from a register, clear = immediate encoding.
REQ-008 SHALL have port Req_Cin, input, 2; carry-in for requester k.
REQ-009 SHALL have port Gnt, output, 2; one-hot grant, high for exactly the acceptance cycle.
REQ-010 SHALL have port Res_Valid, output, 1; result held valid.
REQ-011 SHALL have port Res_Ready, input, 1; consumer accepts the result.
REQ-012 SHALL have ports Res_Data (output, 32), Res_Cout (output, 1) and Res_Id (output, 1, index of the granted requester).
REQ-013 SHALL have shifter drive outputs BS_Enable (1), BS_Input_Bus (32), BS_Shift_Type (2), BS_Shift_Amt (5) and BS_Cin (1).
REQ-014 SHALL have shifter return inputs BS_Shift_Output (32) and BS_Cout (1); the shifter is combinational.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-016 IDLE: with any Req bit set, SHALL grant one requester, assert its Gnt combinationally, capture its operands at the edge and go to SHIFT.
REQ-017 Arbitration SHALL be round-robin: the pointer starts at 0 and, on each result handshake, moves to the requester not just served; with a single request, that requester wins.
REQ-018 SHIFT: SHALL drive BS_* from the captured operands with BS_Enable=1, register the post-fixed result into Res_Data/Res_Cout, set Res_Valid, and go to DONE.
REQ-019 DONE: SHALL hold Res_* stable until Res_Valid&Res_Ready; on that edge SHALL clear Res_Valid and go to IDLE.
REQ-020 Gnt SHALL be 0 in SHIFT and DONE; requests there SHALL wait; latency is 2 cycles from grant to Res_Valid; throughput is at most one shift per 3 cycles.
REQ-021 Immediate mode: SHALL pass Amt[4:0] unchanged to the shifter and ignore Amt[7:5]; amount 0 keeps the shifter's special encodings (LSR/ASR #32, RRX).
REQ-022 Outside SHIFT, BS_Enable SHALL be 0 and the other BS_* outputs SHALL hold the captured values.

Reset
REQ-023 On nRESET low, SHALL immediately enter IDLE, clear Gnt, Res_Valid, Res_Data, Res_Cout, Res_Id, BS_Enable and all capture registers, and set the pointer to 0; an in-flight result SHALL be discarded.
REQ-024 After nRESET rises, the first grant SHALL occur no earlier than the first rising CLK edge.

Configuration
REQ-025 Macro SHIFTER_ARB_REGSHIFT_EN SHALL enable register-shift fix-up when Req_RegShift is set, using the 8-bit amount N.
REQ-026 With the macro, register-shift fix-up SHALL be:
- N=0: BS_Enable=0, so data passes unchanged and Cout=Cin.
- N in 1..31: normal shift.
- LSL, N=32: result 0, Cout=data[0].
- LSL, N>32: result 0, Cout=0.
- LSR, N=32: result 0, Cout=data[31].
- LSR, N>32: result 0, Cout=0.
- ASR, N>=32: all bits = data[31], Cout=data[31].
- ROR, N[4:0]=0 with N>0: data unchanged, Cout=data[31].
- ROR, otherwise: rotate by N[4:0].
REQ-027 Without the macro, Req_RegShift SHALL be ignored and all requests SHALL use immediate mode (REQ-021).

Verification
REQ-028 Req=01, Data0=0x0000_00F0, LSL, Amt=4, imm -> Gnt=01; 2 cycles later Res_Valid=1, Res_Data=0x0000_0F00, Cout=0, Id=0.
REQ-029 Req=11 held, Res_Ready=1 -> grants alternate 01,10,01, each separated by 3 cycles.
REQ-030 Res_Ready=0 for 5 cycles in DONE with Req=10 pending -> Res_* stable, Gnt=00 until the handshake.
REQ-031 With the macro, LSR, N=40, RegShift, Data=0x8000_0001 -> Res_Data=0, Cout=0; same with N=32 -> Cout=1.
REQ-032 With the macro, ROR, N=64, RegShift, Data=0x8000_0000 -> Res_Data=0x8000_0000, Cout=1; without the macro -> RRX result 0x4000_0000|Cin<<31, Cout=0.
REQ-033 nRESET pulsed low in SHIFT -> Res_Valid=0 and BS_Enable=0 asynchronously; the next grant goes to requester 0.
